// File: rtl/pmt_gate_sequencer.sv
// Gated PMT photon counter: runs num_windows gates of window_len cycles each, hands off each count.
// Optional macro PMT_DEAD_TIME_EN adds a DEAD_CYC-cycle dead time after every counted pulse.
module pmt_gate_sequencer #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 16,
   parameter int IDX_W = 8
`ifdef PMT_DEAD_TIME_EN
   ,
   parameter int DEAD_CYC = 4
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] window_len,
   input  logic [IDX_W-1:0] num_windows,
   input  logic             pmt_pulse,
   input  logic             rd_ack,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   output logic [IDX_W-1:0] window_idx,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, COUNT, HOLD, DONE} state_t;

   state_t           state, state_d;
   logic [WIN_W-1:0] len_q, cyc_q;
   logic [IDX_W-1:0] num_q, idx_q;
   logic [CNT_W-1:0] acc_q, cnt_q, acc_inc;
   logic             ovf_q, ovf_out_q, valid_q, ovf_inc;
   logic             start_ok, last_cyc, last_win, pulse_ok, acc_sat, win_start;

   assign start_ok  = start && (window_len != '0) && (num_windows != '0);
   assign last_cyc  = (cyc_q == len_q - WIN_W'(1));
   assign last_win  = (idx_q == num_q - IDX_W'(1));
   assign acc_sat   = &acc_q;
   assign win_start = ((state == IDLE) && start_ok) || ((state == HOLD) && rd_ack && !last_win);

`ifdef PMT_DEAD_TIME_EN
   localparam int DEAD_W = $clog2(DEAD_CYC + 1);
   logic [DEAD_W-1:0] dead_q;

   assign pulse_ok = pmt_pulse && (dead_q == '0);

   always_ff @(posedge clk) begin
      if (!reset || abort || win_start)
         dead_q <= '0;
      else if (state == COUNT) begin
         if (pulse_ok)
            dead_q <= DEAD_W'(DEAD_CYC);
         else if (dead_q != '0)
            dead_q <= dead_q - DEAD_W'(1);
      end
   end
`else
   assign pulse_ok = pmt_pulse;
`endif

   // A pulse at saturation leaves the count pinned and raises the window overflow flag.
   assign acc_inc = (pulse_ok && !acc_sat) ? acc_q + CNT_W'(1) : acc_q;
   assign ovf_inc = ovf_q | (pulse_ok && acc_sat);

   // NOTE: state register uses non-blocking assignment; next-state logic is purely combinational.
   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start_ok) state_d = COUNT;
         COUNT:   if (last_cyc) state_d = HOLD;
         HOLD:    if (rd_ack)   state_d = last_win ? DONE : COUNT;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort)
         state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         len_q     <= '0;
         num_q     <= '0;
         cyc_q     <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
         ovf_out_q <= 1'b0;
         valid_q   <= 1'b0;
      end else if (abort) begin
         cyc_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_ok) begin
               len_q <= window_len;
               num_q <= num_windows;
               idx_q <= '0;
               cyc_q <= '0;
               acc_q <= '0;
               ovf_q <= 1'b0;
            end
            COUNT: begin
               acc_q <= acc_inc;
               ovf_q <= ovf_inc;
               cyc_q <= cyc_q + WIN_W'(1);
               if (last_cyc) begin
                  cyc_q     <= '0;
                  cnt_q     <= acc_inc;
                  ovf_out_q <= ovf_inc;
                  valid_q   <= 1'b1;
               end
            end
            HOLD: if (rd_ack) begin
               valid_q <= 1'b0;
               if (!last_win) begin
                  idx_q <= idx_q + IDX_W'(1);
                  acc_q <= '0;
                  ovf_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign count_out   = cnt_q;
   assign count_valid = valid_q;
   assign window_idx  = idx_q;
   assign overflow    = ovf_out_q;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

endmodule

// File: tb/tb_pmt_gate_sequencer.sv
// Directed self-checking bench for pmt_gate_sequencer; a second CNT_W=4 instance exercises saturation.
module tb_pmt_gate_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, abort, pmt_pulse, rd_ack;
   logic [15:0] window_len;
   logic [7:0]  num_windows;
   logic [15:0] count_out;
   logic [3:0]  s_count_out;
   logic [7:0]  window_idx, s_window_idx;
   logic        count_valid, overflow, busy, done;
   logic        s_count_valid, s_overflow, s_busy, s_done;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef PMT_DEAD_TIME_EN
   localparam int EXP_B   = 2;   // pulses at 1,5,10: 5 falls in dead time
   localparam int EXP_C   = 1;
   localparam int EXP_D   = 4;
   localparam int EXP_DS  = 4;
   localparam int EXP_DSO = 0;
   localparam int EXP_E   = 1;
   localparam int EXP_G   = 2;
`else
   localparam int EXP_B   = 3;
   localparam int EXP_C   = 4;
   localparam int EXP_D   = 20;
   localparam int EXP_DS  = 15;
   localparam int EXP_DSO = 1;
   localparam int EXP_E   = 3;
   localparam int EXP_G   = 10;
`endif

   pmt_gate_sequencer u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .window_len(window_len), .num_windows(num_windows),
      .pmt_pulse(pmt_pulse), .rd_ack(rd_ack),
      .count_out(count_out), .count_valid(count_valid), .window_idx(window_idx),
      .overflow(overflow), .busy(busy), .done(done)
   );

   pmt_gate_sequencer #(.CNT_W(4)) u_small (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .window_len(window_len), .num_windows(num_windows),
      .pmt_pulse(pmt_pulse), .rd_ack(rd_ack),
      .count_out(s_count_out), .count_valid(s_count_valid), .window_idx(s_window_idx),
      .overflow(s_overflow), .busy(s_busy), .done(s_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int len, input int num);
      window_len  = 16'(len);
      num_windows = 8'(num);
      start       = 1'b1;
      tick();
      start = 1'b0;
   endtask

   int strobes, dones;

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; pmt_pulse = 1'b0; rd_ack = 1'b0;
      window_len = '0; num_windows = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_valid", count_valid, 0);
      check("rst_count", count_out, 0);
      check("rst_done", done, 0);
      check("rst_idx", window_idx, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b1;
      tick();

      // zero parameters: start ignored
      start_run(0, 1);
      check("zero_len_busy", busy, 0);
      start_run(5, 0);
      check("zero_num_busy", busy, 0);

      // single 10-cycle window, pulses at 1, 5, 10; stray rd_ack/start in COUNT ignored
      start_run(10, 1);
      check("b_busy", busy, 1);
      for (int c = 1; c <= 10; c++) begin
         pmt_pulse = (c == 1 || c == 5 || c == 10);
         rd_ack    = (c == 3);
         start     = (c == 4);
         window_len = (c == 4) ? 16'd2 : 16'd10;
         tick();
         if (c == 9) check("b_valid_early", count_valid, 0);
      end
      pmt_pulse = 1'b0; rd_ack = 1'b0; start = 1'b0;
      check("b_valid", count_valid, 1);
      check("b_count", count_out, EXP_B);
      check("b_idx", window_idx, 0);
      pmt_pulse = 1'b1;
      tick(); tick();
      pmt_pulse = 1'b0;
      check("b_hold_count", count_out, EXP_B);
      check("b_hold_valid", count_valid, 1);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check("b_done", done, 1);
      check("b_valid_clr", count_valid, 0);
      tick();
      check("b_done_pulse", done, 0);
      check("b_idle", busy, 0);

      // three 4-cycle windows, rd_ack tied high, pulse every cycle
      rd_ack = 1'b1; pmt_pulse = 1'b1;
      start_run(4, 3);
      strobes = 0; dones = 0;
      for (int c = 0; c < 30; c++) begin
         if (count_valid) begin
            check("c_count", count_out, EXP_C);
            check("c_idx", window_idx, 32'(strobes));
            strobes++;
         end
         if (done) dones++;
         tick();
      end
      rd_ack = 1'b0; pmt_pulse = 1'b0;
      check("c_strobes", strobes, 3);
      check("c_dones", dones, 1);
      check("c_idle", busy, 0);

      // 20-cycle window, pulse every cycle: small instance saturates
      pmt_pulse = 1'b1;
      start_run(20, 1);
      repeat (20) tick();
      pmt_pulse = 1'b0;
      check("d_valid", count_valid, 1);
      check("d_count", count_out, EXP_D);
      check("d_ovf", overflow, 0);
      check("d_small_count", s_count_out, EXP_DS);
      check("d_small_ovf", s_overflow, EXP_DSO);
      rd_ack = 1'b1; tick(); rd_ack = 1'b0; tick();
      check("d_idle", busy, 0);

      // abort in 3rd COUNT cycle of window 1 of 2, overriding start and rd_ack
      pmt_pulse = 1'b1;
      start_run(5, 2);
      tick(); tick();
      abort = 1'b1; start = 1'b1; rd_ack = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0; rd_ack = 1'b0;
      check("e_busy", busy, 0);
      strobes = 0; dones = 0;
      for (int c = 0; c < 8; c++) begin
         if (count_valid) strobes++;
         if (done) dones++;
         tick();
      end
      check("e_no_valid", strobes, 0);
      check("e_no_done", dones, 0);
      start_run(3, 1);
      check("e_restart_busy", busy, 1);
      repeat (3) tick();
      pmt_pulse = 1'b0;
      check("e_restart_valid", count_valid, 1);
      check("e_restart_count", count_out, EXP_E);

      // reset during HOLD
      reset = 1'b0;
      tick();
      check("f_valid", count_valid, 0);
      check("f_count", count_out, 0);
      check("f_busy", busy, 0);
      check("f_idx", window_idx, 0);
      check("f_ovf", overflow, 0);
      check("f_done", done, 0);
      reset = 1'b1;
      tick();

      // 10-cycle window, pulse every cycle (dead-time comparison)
      pmt_pulse = 1'b1;
      start_run(10, 1);
      repeat (10) tick();
      pmt_pulse = 1'b0;
      check("g_valid", count_valid, 1);
      check("g_count", count_out, EXP_G);
      rd_ack = 1'b1; tick(); rd_ack = 1'b0; tick();
      check("g_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
